// File: rtl/seg_scan_driver_pkg.sv
// Shared constants for the multiplexed 4-digit 7-segment scan driver:
// active-low segment codes, anode idle pattern and digit slot indices.
package seg_scan_driver_pkg;

    // Segment patterns {g,f,e,d,c,b,a}, active-low
    localparam logic [6:0] SEG_0    = 7'h40;
    localparam logic [6:0] SEG_1    = 7'h79;
    localparam logic [6:0] SEG_2    = 7'h24;
    localparam logic [6:0] SEG_3    = 7'h30;
    localparam logic [6:0] SEG_4    = 7'h19;
    localparam logic [6:0] SEG_5    = 7'h12;
    localparam logic [6:0] SEG_6    = 7'h02;
    localparam logic [6:0] SEG_7    = 7'h78;
    localparam logic [6:0] SEG_8    = 7'h00;
    localparam logic [6:0] SEG_9    = 7'h10;
    localparam logic [6:0] SEG_DASH = 7'h3F;
    localparam logic [6:0] SEG_OFF  = 7'h7F;

    localparam logic [3:0] AN_OFF   = 4'b1111;

    localparam logic [1:0] IDX_SO   = 2'd0;
    localparam logic [1:0] IDX_ST   = 2'd1;
    localparam logic [1:0] IDX_MO   = 2'd2;
    localparam logic [1:0] IDX_MT   = 2'd3;

endpackage

// File: rtl/seg_scan_driver_bcd_to_seg.sv
// Combinational BCD to active-low 7-segment decoder; codes 10-15 show a dash.
module bcd_to_seg
    import seg_scan_driver_pkg::*;
(
    input  logic [3:0] i_digit,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_DASH;
        case (i_digit)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Scans four snapshotted BCD digits onto a common-anode display, with a blank
// guard cycle at every slot change and blinking of the field under adjustment.
module seg_scan_driver
    import seg_scan_driver_pkg::*;
#(
    parameter int SCAN_DIV  = 100000,
    parameter int BLINK_DIV = 25000000
) (
    input  logic       clk,
    input  logic       RESET_N,
    input  logic [2:0] min_tens,
    input  logic [3:0] min_ones,
    input  logic [2:0] sec_tens,
    input  logic [3:0] sec_ones,
    input  logic       ADJ,
    input  logic       SEL,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an
);

    localparam int SCAN_W  = $clog2(SCAN_DIV);
    localparam int BLINK_W = $clog2(BLINK_DIV + 1);
    localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

    logic [SCAN_W-1:0]  r_scan_cnt;
    logic [1:0]         r_digit_idx;
    logic [3:0]         r_snap [4];
    logic [BLINK_W-1:0] r_blink_cnt;
    logic               r_blink_on;
    logic [3:0]         r_an;
    logic [6:0]         r_seg;
    logic               r_dp;

    logic               w_scan_last;
    logic [SCAN_W-1:0]  w_scan_next;
    logic [1:0]         w_idx_next;
    logic               w_blink_last;
    logic               w_blink_on_next;
    logic               w_in_field;
    logic               w_blank_next;
    logic [3:0]         w_an_next;
    logic [3:0]         w_digit;
    logic [6:0]         w_seg;

    // The anode register is computed from next-state values so the guard
    // cycle lines up exactly with scan_cnt==0 of each slot.
    always_comb begin
        w_scan_last     = (r_scan_cnt == SCAN_LAST);
        w_scan_next     = w_scan_last ? '0 : r_scan_cnt + 1'b1;
        w_idx_next      = w_scan_last ? r_digit_idx + 2'd1 : r_digit_idx;
        w_blink_last    = (r_blink_cnt == BLINK_LAST);
        w_blink_on_next = ADJ ? (w_blink_last ? ~r_blink_on : r_blink_on) : 1'b1;
        w_in_field      = SEL ? w_idx_next[1] : ~w_idx_next[1];
        w_blank_next    = ADJ & ~w_blink_on_next & w_in_field;
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_an
        assign w_an_next[gi] = (w_scan_next == '0) || w_blank_next
                               || (w_idx_next != 2'(gi));
    end

    assign w_digit = r_snap[r_digit_idx];

    bcd_to_seg u_bcd_to_seg (
        .i_digit (w_digit),
        .o_seg   (w_seg)
    );

    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            r_scan_cnt  <= '0;
            r_digit_idx <= IDX_SO;
            for (int i = 0; i < 4; i++) r_snap[i] <= 4'd0;
            r_blink_cnt <= '0;
            r_blink_on  <= 1'b1;
            r_an        <= AN_OFF;
            r_seg       <= SEG_OFF;
            r_dp        <= 1'b1;
        end else begin
            r_scan_cnt  <= w_scan_next;
            r_digit_idx <= w_idx_next;
            // Whole-frame snapshot taken together with the 3->0 slot wrap
            if (w_scan_last && (r_digit_idx == IDX_MT)) begin
                r_snap[IDX_SO] <= sec_ones;
                r_snap[IDX_ST] <= {1'b0, sec_tens};
                r_snap[IDX_MO] <= min_ones;
                r_snap[IDX_MT] <= {1'b0, min_tens};
            end
            if (ADJ) r_blink_cnt <= w_blink_last ? '0 : r_blink_cnt + 1'b1;
            else     r_blink_cnt <= '0;
            r_blink_on  <= w_blink_on_next;
            r_an        <= w_an_next;
            r_seg       <= w_seg;
            r_dp        <= (r_digit_idx != IDX_MO);
        end
    end

    assign an  = r_an;
    assign seg = r_seg;
    assign dp  = r_dp;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with SCAN_DIV=4, BLINK_DIV=16.
module tb_seg_scan_driver;

    logic       clk;
    logic       RESET_N;
    logic [2:0] min_tens;
    logic [3:0] min_ones;
    logic [2:0] sec_tens;
    logic [3:0] sec_ones;
    logic       ADJ;
    logic       SEL;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;

    int checks = 0;
    int errors = 0;
    int k      = 0;   // posedges since the last reset release

    typedef struct {
        string      name;
        int         k;
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } vec_t;

    vec_t scan_tbl[11];
    vec_t rst_tbl[4];

    seg_scan_driver #(.SCAN_DIV(4), .BLINK_DIV(16)) dut (
        .clk      (clk),
        .RESET_N  (RESET_N),
        .min_tens (min_tens),
        .min_ones (min_ones),
        .sec_tens (sec_tens),
        .sec_ones (sec_ones),
        .ADJ      (ADJ),
        .SEL      (SEL),
        .seg      (seg),
        .dp       (dp),
        .an       (an)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        k++;
    endtask

    task automatic run_to(input int target);
        while (k < target) tick();
    endtask

    task automatic check(input string name, input logic [3:0] ea,
                         input logic [6:0] es, input logic ed);
        checks++;
        if (an !== ea || seg !== es || dp !== ed) begin
            errors++;
            $display("FAIL %s k=%0d: got an=%b seg=%h dp=%b, want an=%b seg=%h dp=%b",
                     name, k, an, seg, dp, ea, es, ed);
        end else begin
            $display("ok   %s k=%0d: an=%b seg=%h dp=%b", name, k, an, seg, dp);
        end
    endtask

    task automatic check_an(input string name, input logic [3:0] ea);
        checks++;
        if (an !== ea) begin
            errors++;
            $display("FAIL %s k=%0d: got an=%b, want an=%b", name, k, an, ea);
        end
    endtask

    initial begin
        int slot;
        int phase;
        logic sel_eff;
        logic hide;
        logic [3:0] exp_an;

        scan_tbl[0]  = '{"frame0_s0",     1, 4'b1110, 7'h40, 1'b1};
        scan_tbl[1]  = '{"frame0_guard",  4, 4'b1111, 7'h40, 1'b1};
        scan_tbl[2]  = '{"s0_secones",   17, 4'b1110, 7'h19, 1'b1};
        scan_tbl[3]  = '{"guard_s1",     20, 4'b1111, 7'h19, 1'b1};
        scan_tbl[4]  = '{"s1_sectens",   21, 4'b1101, 7'h30, 1'b1};
        scan_tbl[5]  = '{"guard_s2",     24, 4'b1111, 7'h30, 1'b1};
        scan_tbl[6]  = '{"s2_minones",   25, 4'b1011, 7'h24, 1'b0};
        scan_tbl[7]  = '{"guard_s3",     28, 4'b1111, 7'h24, 1'b0};
        scan_tbl[8]  = '{"s3_mintens",   29, 4'b0111, 7'h79, 1'b1};
        scan_tbl[9]  = '{"guard_s0",     32, 4'b1111, 7'h79, 1'b1};
        scan_tbl[10] = '{"s0_again",     33, 4'b1110, 7'h19, 1'b1};

        rst_tbl[0] = '{"rst_s0_zero",   1, 4'b1110, 7'h40, 1'b1};
        rst_tbl[1] = '{"rst_s0_dash",  17, 4'b1110, 7'h3F, 1'b1};
        rst_tbl[2] = '{"rst_s2",       25, 4'b1011, 7'h24, 1'b0};
        rst_tbl[3] = '{"rst_s3",       29, 4'b0111, 7'h79, 1'b1};

        min_tens = 3'd1; min_ones = 4'd2; sec_tens = 3'd3; sec_ones = 4'd4;
        ADJ = 1'b0; SEL = 1'b0;

        // Reset acts without a clock edge
        RESET_N = 1'b1;
        #1 RESET_N = 1'b0;
        #1 check("reset_async", 4'b1111, 7'h7F, 1'b1);
        @(negedge clk) RESET_N = 1'b1;
        k = 0;

        for (int i = 0; i < 11; i++) begin
            run_to(scan_tbl[i].k);
            check(scan_tbl[i].name, scan_tbl[i].an, scan_tbl[i].seg, scan_tbl[i].dp);
        end

        // Coherence: change sec_ones while slot 1 is showing
        run_to(37);
        sec_ones = 4'd5;
        run_to(38); check("coh_s1",     4'b1101, 7'h30, 1'b1);
        run_to(47); check("coh_s3",     4'b0111, 7'h79, 1'b1);
        run_to(48); check("coh_guard",  4'b1111, 7'h79, 1'b1);
        run_to(49); check("coh_new_s0", 4'b1110, 7'h12, 1'b1);

        // Blink: ADJ rises for edge 50; 16 edges visible then 16 hidden
        ADJ = 1'b1;
        SEL = 1'b0;
        for (int kk = 50; kk <= 137; kk++) begin
            run_to(kk);
            slot    = (kk / 4) % 4;
            phase   = ((kk - 49) / 16) % 2;
            sel_eff = (kk >= 113);
            hide    = (phase == 1) && (sel_eff ? (slot >= 2) : (slot < 2));
            exp_an  = 4'b1111;
            if ((kk % 4) != 0 && !hide) exp_an[slot] = 1'b0;
            check_an(sel_eff ? "blink_sel1" : "blink_sel0", exp_an);
            if (kk == 112) SEL = 1'b1;
        end

        // Exit adjust mid-hidden phase (slot 2 blanked at k=137)
        ADJ = 1'b0;
        run_to(138); check_an("exit_s2", 4'b1011);
        run_to(141); check_an("exit_s3", 4'b0111);
        run_to(145); check_an("exit_s0", 4'b1110);
        run_to(149); check_an("exit_s1", 4'b1101);
        run_to(153); check_an("exit_s2b", 4'b1011);

        // Invalid code shows a dash from the next frame
        sec_ones = 4'hB;
        run_to(157); check("inv_s3_old", 4'b0111, 7'h79, 1'b1);
        run_to(161); check("inv_dash",   4'b1110, 7'h3F, 1'b1);

        // Reset in the middle of slot 2
        run_to(170);
        #2 RESET_N = 1'b0;
        #1 check("reset_mid", 4'b1111, 7'h7F, 1'b1);
        @(posedge clk);
        #1 check("reset_held", 4'b1111, 7'h7F, 1'b1);
        @(negedge clk) RESET_N = 1'b1;
        k = 0;
        for (int i = 0; i < 4; i++) begin
            run_to(rst_tbl[i].k);
            check(rst_tbl[i].name, rst_tbl[i].an, rst_tbl[i].seg, rst_tbl[i].dp);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
